game_sequencer: RTL and testbench

- Top-level play-state controller for the breakout game.
- Decides when the ball integrator may advance, using do_move qualified by frame_pulse.
- Requests ball repositioning for each serve.
- Tracks remaining lives and detects ball loss and level clear.
- Sits between the VGA timing generator (frame_pulse), the player input, the ball/brick logic, and the HUD renderer (lives, state, blink).

---
 rtl/game_sequencer.sv | 119 +++++++++++
 tb/tb_game_sequencer.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/game_sequencer.sv
// Breakout play-state controller: serve/play/lost sequencing, lives tracking,
// frame-qualified ball movement enable and HUD blink phase.
module game_sequencer #(
    parameter logic [2:0] LIVES         = 3'd3,
    parameter logic [8:0] FLOOR_Y       = 9'd472,
    parameter logic [7:0] SERVE_TIMEOUT = 8'd180,
    parameter logic [7:0] PAUSE_FRAMES  = 8'd60,
    parameter int         BLINK_SHIFT   = 4
) (
    input  logic       clk,
    input  logic       nRst,
    input  logic       frame_pulse,
    input  logic       launch_btn,
    input  logic [8:0] ball_y,
    input  logic       bricks_cleared,
    output logic       do_move,
    output logic       ball_reload,
    output logic       game_start,
    output logic [2:0] lives,
    output logic [2:0] state,
    output logic       blink
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        SERVE     = 3'd1,
        PLAY      = 3'd2,
        LOST      = 3'd3,
        GAME_OVER = 3'd4,
        WIN       = 3'd5
    } state_t;

    state_t     st, state_nxt;
    logic [2:0] lives_nxt;
    logic       reload_nxt, start_nxt;
    logic [7:0] frame_cnt;
    logic       btn_meta, btn_sync, btn_prev;
    logic       press;

    assign state = st;
    // btn_prev only moves on frames, so one press per frame at most (debounce)
    assign press = frame_pulse & btn_sync & ~btn_prev;

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            btn_meta <= 1'b0;
            btn_sync <= 1'b0;
        end else begin
            btn_meta <= launch_btn;
            btn_sync <= btn_meta;
        end
    end

    always_comb begin
        state_nxt  = st;
        lives_nxt  = lives;
        reload_nxt = 1'b0;
        start_nxt  = 1'b0;
        if (frame_pulse) begin
            case (st)
                IDLE: if (press) begin
                    state_nxt  = SERVE;
                    lives_nxt  = LIVES;
                    reload_nxt = 1'b1;
                    start_nxt  = 1'b1;
                end
                SERVE: if (press || (SERVE_TIMEOUT != 8'd0 && frame_cnt == SERVE_TIMEOUT - 8'd1))
                    state_nxt = PLAY;
                PLAY: begin
                    if (bricks_cleared) begin
                        state_nxt = WIN;
                    end else if (ball_y >= FLOOR_Y) begin
                        state_nxt = LOST;
                        if (lives != 3'd0) lives_nxt = lives - 3'd1;
                    end
                end
                LOST: if (frame_cnt == PAUSE_FRAMES - 8'd1) begin
                    if (lives == 3'd0) begin
                        state_nxt = GAME_OVER;
                    end else begin
                        state_nxt  = SERVE;
                        reload_nxt = 1'b1;
                    end
                end
                GAME_OVER, WIN: if (press) state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            st          <= IDLE;
            lives       <= LIVES;
            frame_cnt   <= 8'd0;
            blink       <= 1'b0;
            do_move     <= 1'b0;
            ball_reload <= 1'b0;
            game_start  <= 1'b0;
            btn_prev    <= 1'b0;
        end else begin
            st          <= state_nxt;
            lives       <= lives_nxt;
            ball_reload <= reload_nxt;
            game_start  <= start_nxt;
            do_move     <= (state_nxt == PLAY);
            if (frame_pulse) btn_prev <= btn_sync;
            if (state_nxt != st)
                frame_cnt <= 8'd0;
            else if (frame_pulse && frame_cnt != 8'hff)
                frame_cnt <= frame_cnt + 8'd1;
            if (state_nxt == PLAY)
                blink <= 1'b0;
            else if (frame_pulse && (&frame_cnt[BLINK_SHIFT-1:0]))
                blink <= ~blink;
        end
    end

endmodule

// File: tb/tb_game_sequencer.sv
// Randomized bench for game_sequencer with a frame-level reference model.
module tb_game_sequencer;

    localparam int LIVES_P  = 3;
    localparam int FLOOR_P  = 472;
    localparam int SERVE_P  = 4;
    localparam int PAUSE_P  = 60;
    localparam int BLINK_P  = 16;

    logic       clk = 1'b0;
    logic       nRst = 1'b0;
    logic       frame_pulse = 1'b0;
    logic       launch_btn = 1'b0;
    logic [8:0] ball_y = 9'd100;
    logic       bricks_cleared = 1'b0;
    logic       do_move, ball_reload, game_start, blink;
    logic [2:0] lives, state;

    int n_tests = 0;
    int n_fail  = 0;

    // reference model, one update per frame
    int m_state, m_lives, m_cnt, m_blink, m_prev, m_reload, m_start;

    game_sequencer #(
        .LIVES(3'd3), .FLOOR_Y(9'd472), .SERVE_TIMEOUT(8'd4),
        .PAUSE_FRAMES(8'd60), .BLINK_SHIFT(4)
    ) dut (
        .clk(clk), .nRst(nRst), .frame_pulse(frame_pulse), .launch_btn(launch_btn),
        .ball_y(ball_y), .bricks_cleared(bricks_cleared), .do_move(do_move),
        .ball_reload(ball_reload), .game_start(game_start), .lives(lives),
        .state(state), .blink(blink)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_state = 0; m_lives = LIVES_P; m_cnt = 0; m_blink = 0; m_prev = 0;
        m_reload = 0; m_start = 0;
    endtask

    task automatic model_frame(input int b, input int y, input int bc);
        int  nxt;
        bit  pressed;
        pressed  = (b == 1) && (m_prev == 0);
        m_prev   = b;
        nxt      = m_state;
        m_reload = 0;
        m_start  = 0;
        if (m_state == 0 && pressed) begin
            nxt = 1; m_lives = LIVES_P; m_reload = 1; m_start = 1;
        end else if (m_state == 1 && (pressed || m_cnt == SERVE_P - 1)) begin
            nxt = 2;
        end else if (m_state == 2 && bc == 1) begin
            nxt = 5;
        end else if (m_state == 2 && y >= FLOOR_P) begin
            nxt = 3;
            m_lives = (m_lives > 0) ? m_lives - 1 : 0;
        end else if (m_state == 3 && m_cnt == PAUSE_P - 1) begin
            if (m_lives == 0) nxt = 4;
            else begin nxt = 1; m_reload = 1; end
        end else if ((m_state == 4 || m_state == 5) && pressed) begin
            nxt = 0;
        end
        if (nxt == 2) m_blink = 0;
        else if (m_cnt % BLINK_P == BLINK_P - 1) m_blink = 1 - m_blink;
        m_cnt   = (nxt != m_state) ? 0 : ((m_cnt < 255) ? m_cnt + 1 : 255);
        m_state = nxt;
    endtask

    task automatic check_outputs(input string where);
        check({where, ".state"}, state, m_state);
        check({where, ".lives"}, lives, m_lives);
        check({where, ".do_move"}, do_move, (m_state == 2) ? 1 : 0);
        check({where, ".blink"}, blink, m_blink);
    endtask

    task automatic do_frame(input int b, input int y, input int bc);
        @(negedge clk);
        launch_btn = b[0]; ball_y = y[8:0]; bricks_cleared = bc[0];
        repeat (3 + $urandom_range(0, 2)) @(negedge clk);
        frame_pulse = 1'b1;
        model_frame(b, y, bc);
        @(negedge clk);
        frame_pulse = 1'b0;
        check_outputs("frame");
        check("frame.ball_reload", ball_reload, m_reload);
        check("frame.game_start", game_start, m_start);
        @(negedge clk);
        check("after.ball_reload", ball_reload, 0);
        check("after.game_start", game_start, 0);
        check("after.do_move", do_move, (m_state == 2) ? 1 : 0);
    endtask

    task automatic run_until(input int target, input int y, input int limit);
        int k;
        k = 0;
        while (m_state != target && k < limit) begin
            do_frame(0, (m_state == 2) ? y : 100, 0);
            k++;
        end
        check("reach_state", state, target);
    endtask

    initial begin
        model_reset();
        repeat (3) @(negedge clk);
        check_outputs("reset");
        check("reset.ball_reload", ball_reload, 0);
        check("reset.game_start", game_start, 0);
        nRst = 1'b1;

        // button held over two frames: a single start
        do_frame(1, 100, 0);
        check("start.state", state, 1);
        do_frame(1, 100, 0);
        run_until(2, 100, 10);
        do_frame(0, 471, 0);
        check("floor471.state", state, 2);
        do_frame(0, 472, 0);
        check("floor472.lives", lives, 2);
        run_until(1, 100, 70);

        // lose the remaining balls
        run_until(4, 480, 400);
        check("gameover.lives", lives, 0);
        do_frame(1, 100, 0);
        check("restart.state", state, 0);

        // win has priority over a simultaneous loss
        do_frame(0, 100, 0);
        do_frame(1, 100, 0);
        run_until(2, 100, 10);
        do_frame(0, 480, 1);
        check("win.state", state, 5);
        check("win.lives", lives, 3);
        do_frame(1, 100, 0);
        do_frame(0, 100, 0);

        // asynchronous reset in the middle of play
        do_frame(1, 100, 0);
        run_until(2, 100, 10);
        @(negedge clk);
        #2 nRst = 1'b0;
        #1;
        check("async.do_move", do_move, 0);
        check("async.state", state, 0);
        check("async.lives", lives, 3);
        model_reset();
        launch_btn = 1'b0;
        repeat (2) @(negedge clk);
        nRst = 1'b1;
        for (int i = 0; i < 3; i++) do_frame(0, 100, 0);

        // randomized play
        for (int i = 0; i < 600; i++) begin
            int b, y, bc;
            b  = $urandom_range(0, 1);
            y  = ($urandom_range(0, 7) == 0) ? $urandom_range(465, 511) : $urandom_range(0, 464);
            bc = ($urandom_range(0, 31) == 0) ? 1 : 0;
            do_frame(b, y, bc);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
